// File: rtl/spi_clock_gen.sv
// SPI master serial-clock generator: paces sclk from a programmable divider and frames each transfer with go_busy/done.
// Optional build macro SPI_CLKGEN_CPOL_EN adds the cpol input and a programmable sclk idle level.
module spi_clock_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [DIV_W-1:0] divider,
  input  logic [6:0]       char_len,
`ifdef SPI_CLKGEN_CPOL_EN
  input  logic             cpol,
`endif
  output logic             sclk,
  output logic             go_busy,
  output logic             pos_edge,
  output logic             neg_edge,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // go is sampled only in IDLE; divider/char_len are captured there and held for the whole transfer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [6:0]       len_q, len_d;
  logic [7:0]       edges_q, edges_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             pos_q, pos_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic             idle_lvl;

`ifdef SPI_CLKGEN_CPOL_EN
  assign idle_lvl = cpol;
`else
  assign idle_lvl = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      edges_q <= '0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      edges_q <= edges_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    edges_d = edges_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = idle_lvl;
        busy_d = 1'b0;
        if (go) begin
          div_d   = divider;
          len_d   = char_len;
          cnt_d   = div_d;
          // 2*N in 8 bits: a length of 128 (encoded 0) loads 0 and wraps
          // through 255 on its first edge, giving exactly 256 edges.
          edges_d = {len_d, 1'b0};
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          sclk_d  = ~sclk_q;
          pos_d   = ~sclk_q;
          neg_d   = sclk_q;
          cnt_d   = div_q;
          edges_d = edges_q - 8'd1;
          if (edges_q == 8'd1) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign sclk      = sclk_q;
  assign go_busy   = busy_q;
  assign pos_edge  = pos_q;
  assign neg_edge  = neg_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_clock_gen.sv
// Self-checking bench for spi_clock_gen: every cycle of a transfer is compared against
// an arithmetic timeline derived from divider/char_len (edge every divider+1 cycles).
module tb_spi_clock_gen;

  logic        clk;
  logic        reset;
  logic        go;
  logic [15:0] divider;
  logic [6:0]  char_len;
`ifdef SPI_CLKGEN_CPOL_EN
  logic        cpol;
`endif
  logic        sclk;
  logic        go_busy;
  logic        pos_edge;
  logic        neg_edge;
  logic        done;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  spi_clock_gen #(.DIV_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .divider   (divider),
    .char_len  (char_len),
`ifdef SPI_CLKGEN_CPOL_EN
    .cpol      (cpol),
`endif
    .sclk      (sclk),
    .go_busy   (go_busy),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic tb_idle();
`ifdef SPI_CLKGEN_CPOL_EN
    return cpol;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one transfer (unless 'started', meaning the DUT already accepted it at the
  // previous sample edge and we sit at its t=0 negedge) and checks every cycle.
  // t = number of rising edges after the accepting edge.
  task automatic run_transfer(input int d, input int l, input bit hold, input bit disturb,
                              input bit started, input int nd, input int nl);
    int n;
    int tt;
    int tend;
    int npos;
    int nneg;
    int j;
    logic lvl;
    logic is_edge;
    logic [4:0] exp_v;
    logic [4:0] act_v;
    n    = (l == 0) ? 128 : l;
    tt   = 2 * n * (d + 1);
    tend = hold ? tt + 2 : tt + 1;
    npos = 0;
    nneg = 0;
    lvl  = tb_idle();
    if (!started) begin
      @(negedge clk);
      divider  = 16'(d);
      char_len = 7'(l);
      go       = 1'b1;
      @(posedge clk);
    end
    for (int t = 0; t <= tend; t++) begin
      if (!(started && t == 0)) @(negedge clk);
      if (t <= tt) begin
        j       = t / (d + 1);
        is_edge = (t > 0) && (t % (d + 1) == 0);
        exp_v[4] = (t < tt);
        exp_v[3] = (t == tt);
        exp_v[2] = lvl ^ j[0];
        exp_v[1] = is_edge && (lvl ^ j[0]);
        exp_v[0] = is_edge && !(lvl ^ j[0]);
      end else begin
        exp_v = {(hold && t == tt + 2), 1'b0, lvl, 2'b00};
      end
      act_v = {go_busy, done, sclk, pos_edge, neg_edge};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL xfer_cycle d=%0d l=%0d t=%0d busy/done/sclk/pos/neg got %b expected %b",
                 d, l, t, act_v, exp_v);
      end
      if (t <= tt) begin
        npos += int'(pos_edge);
        nneg += int'(neg_edge);
      end
      go = hold || (disturb && (t == 4 || t == 5));
      if (disturb && t == 4) begin
        char_len = 7'd3;
        divider  = 16'($urandom_range(0, 7));
      end
      if (hold && t == tt + 1) begin
        divider  = 16'(nd);
        char_len = 7'(nl);
      end
    end
    checks++;
    if (npos != n || nneg != n) begin
      failures++;
      $display("FAIL edge_count d=%0d l=%0d got pos=%0d neg=%0d expected %0d each",
               d, l, npos, nneg, n);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    go       = 1'b0;
    divider  = '0;
    char_len = '0;
`ifdef SPI_CLKGEN_CPOL_EN
    cpol     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({go_busy, done, sclk, pos_edge, neg_edge} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got %b expected 00000",
               {go_busy, done, sclk, pos_edge, neg_edge});
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({go_busy, done, sclk, pos_edge, neg_edge} !== {2'b00, tb_idle(), 2'b00}) begin
      failures++;
      $display("FAIL idle_after_reset got %b expected %b",
               {go_busy, done, sclk, pos_edge, neg_edge}, {2'b00, tb_idle(), 2'b00});
    end
  endtask

  task automatic test_basic();
    run_transfer(1, 8, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_len128();
    run_transfer(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_large_divider();
    run_transfer(300, 2, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_ignore_changes();
    run_transfer(int'($urandom_range(1, 3)), 8, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int d0, l0, d1, l1;
    d0 = int'($urandom_range(0, 3));
    l0 = int'($urandom_range(1, 6));
    d1 = int'($urandom_range(0, 3));
    l1 = int'($urandom_range(1, 6));
    run_transfer(d0, l0, 1'b1, 1'b0, 1'b0, d1, l1);
    run_transfer(d1, l1, 1'b0, 1'b0, 1'b1, 0, 0);
  endtask

  task automatic test_random();
    repeat (6) begin
      run_transfer(int'($urandom_range(0, 4)), int'($urandom_range(0, 16)),
                   1'b0, 1'b0, 1'b0, 0, 0);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    divider  = 16'd1;
    char_len = 7'd8;
    go       = 1'b1;
    @(posedge clk);
    // fifth sclk period starts at t=18 with divider 1
    for (int t = 0; t <= 19; t++) begin
      @(negedge clk);
      go = 1'b0;
    end
    checks++;
    if (go_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy_before_reset got %b expected 1", go_busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({go_busy, done, sclk, pos_edge, neg_edge} !== 5'b0) begin
      failures++;
      $display("FAIL async_reset_outputs got %b expected 00000",
               {go_busy, done, sclk, pos_edge, neg_edge});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({go_busy, done, pos_edge, neg_edge} !== 4'b0) begin
        failures++;
        $display("FAIL post_reset_idle k=%0d busy/done/pos/neg got %b expected 0000",
                 k, {go_busy, done, pos_edge, neg_edge});
      end
    end
    run_transfer(2, 5, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

`ifdef SPI_CLKGEN_CPOL_EN
  task automatic test_cpol();
    @(negedge clk);
    cpol = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sclk !== 1'b1) begin
      failures++;
      $display("FAIL cpol_idle got %b expected 1", sclk);
    end
    run_transfer(2, 4, 1'b0, 1'b0, 1'b0, 0, 0);
    cpol = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_len128();
    test_large_divider();
    test_ignore_changes();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef SPI_CLKGEN_CPOL_EN
    test_cpol();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
